// File: rtl/tic_tac_toe_board.sv
// -----------------------------------------------------------------------------
// tic_tac_toe_board
//   Board/referee datapath that sits beside the game controller. It holds the
//   3x3 board, accepts or rejects move requests, and reports the status flags
//   the controller steers on.
//
//   Cell index map: 0..8, row-major (0 = top-left, 8 = bottom-right).
//   Cell i occupies board[2i+1:2i].
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-low (priority over everything)
//   playX_en  in   X's turn enable from the controller
//   play0_en  in   O's turn enable from the controller
//   move_vld  in   move request strobe
//   move_pos  in   [3:0] requested cell index, legal 0..8
//   clr       in   synchronous new-game clear, active-high
//   ill       out  one-cycle pulse: the last request was rejected
//   win       out  [1:0] 00 none, 01 X won, 10 O won
//   nospc     out  all nine cells occupied
//   board     out  [17:0] packed board state
//   move_cnt  out  [3:0] accepted moves, 0..9
// -----------------------------------------------------------------------------
module tic_tac_toe_board #(
  parameter logic [1:0] EMPTY = 2'b00,
  parameter logic [1:0] XMARK = 2'b01,
  parameter logic [1:0] OMARK = 2'b10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        playX_en,
  input  logic        play0_en,
  input  logic        move_vld,
  input  logic [3:0]  move_pos,
  input  logic        clr,
  output logic        ill,
  output logic [1:0]  win,
  output logic        nospc,
  output logic [17:0] board,
  output logic [3:0]  move_cnt
);

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [3:0] LAST_POS = 4'd8;
  localparam logic [3:0] MAX_CNT  = 4'd9;

  logic [8:0][1:0] cells_q;
  logic            ill_q;
  logic [1:0]      win_q;
  logic            nospc_q;
  logic [3:0]      cnt_q;

  // Mark owning a completed line, or EMPTY if the line is not complete.
  function automatic logic [1:0] line3(input logic [1:0] a, b, c);
    return (a != EMPTY && a == b && a == c) ? a : EMPTY;
  endfunction

  // First completed line wins; two different winners cannot coexist because
  // the board freezes as soon as a win is registered.
  function automatic logic [1:0] win_of(input logic [8:0][1:0] c);
    logic [7:0][1:0] l;
    l[0] = line3(c[0], c[1], c[2]);
    l[1] = line3(c[3], c[4], c[5]);
    l[2] = line3(c[6], c[7], c[8]);
    l[3] = line3(c[0], c[3], c[6]);
    l[4] = line3(c[1], c[4], c[7]);
    l[5] = line3(c[2], c[5], c[8]);
    l[6] = line3(c[0], c[4], c[8]);
    l[7] = line3(c[2], c[4], c[6]);
    for (int i = 0; i < 8; i++) begin
      if (l[i] != EMPTY) return l[i];
    end
    return WIN_NONE;
  endfunction

  logic       req;
  logic       conflict;
  logic       pos_ok;
  logic       cell_free;
  logic       legal;
  logic       reject;
  logic [1:0] mark;
  logic [1:0] line_win;
  logic       full;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cell_free = 1'b0;
    full      = 1'b1;

    req      = move_vld && (playX_en != play0_en);
    conflict = move_vld && playX_en && play0_en;
    pos_ok   = (move_pos <= LAST_POS);
    if (pos_ok) cell_free = (cells_q[move_pos] == EMPTY);

    legal  = req && pos_ok && cell_free && (win_q == WIN_NONE) && (cnt_q != MAX_CNT);
    reject = conflict || (req && !legal);
    mark   = playX_en ? XMARK : OMARK;

    // Status is derived from the registered board, so win/nospc trail the
    // board by one cycle.
    line_win = win_of(cells_q);
    for (int i = 0; i < 9; i++) begin
      if (cells_q[i] == EMPTY) full = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      // NOTE: the board is nine flop pairs, not a RAM, so it is cleared
      // directly by reset and clr like any other register.
      cells_q <= '0;
      ill_q   <= 1'b0;
      win_q   <= WIN_NONE;
      nospc_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ill_q <= reject;
      if (legal) begin
        cells_q[move_pos] <= mark;
        if (cnt_q != MAX_CNT) cnt_q <= cnt_q + 4'd1;
      end
      // Win is sticky until rst/clr.
      if (win_q == WIN_NONE) win_q <= line_win;
      nospc_q <= full;
    end
  end

  assign ill      = ill_q;
  assign win      = win_q;
  assign nospc    = nospc_q;
  assign board    = cells_q;
  assign move_cnt = cnt_q;

endmodule

// File: doc/tic_tac_toe_board.md
Name: tic_tac_toe_board

Overview:
- Board/referee datapath that sits on the other side of the game controller.
- Consumes the controller's turn enables (playX_en, play0_en) and the player's move request.
- Stores the 3x3 board and produces the status flags the controller steers on: ill, win, nospc.
- Cell index map: 0..8, row-major (0 = top-left, 8 = bottom-right).

Parameters:
- EMPTY, 2'b00, cell encoding for an unoccupied cell.
- XMARK, 2'b01, cell encoding for an X mark; also the win code for X.
- OMARK, 2'b10, cell encoding for an O mark; also the win code for O.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-low.
- playX_en  input  1  X's turn enable, from the controller.
- play0_en  input  1  O's turn enable, from the controller.
- move_vld  input  1  move request strobe, sampled on the clock edge.
- move_pos  input  4  requested cell index; legal range 0..8.
- clr  input  1  synchronous new-game clear, active-high.
- ill  output  1  one-cycle pulse: the last request was rejected.
- win  output  2  00 none, 01 X won, 10 O won; 11 never driven.
- nospc  output  1  all 9 cells occupied.
- board  output  18  cell i occupies bits [2i+1:2i].
- move_cnt  output  4  count of accepted moves, 0..9.

Behaviour:
- Reset: when rst=0 at a clock edge, all cells become EMPTY, ill=0, win=00, nospc=0, move_cnt=0. Reset has priority over everything, mid-game included.
- clr: when clr=1 (and rst=1), same clearing as reset. It has priority over any move presented in the same cycle, and that move is neither written nor flagged.
- A request is a cycle with move_vld=1 and exactly one of playX_en/play0_en high.
- With move_vld=1 and both enables low, nothing happens: no write, no ill.
- Request evaluation, at the clock edge:
  - Illegal if move_pos > 8, or the target cell is not EMPTY, or win != 00, or both enables are high with move_vld=1.
  - Illegal request: the board is unchanged, ill=1 for exactly the following cycle, move_cnt unchanged.
  - Legal request: the target cell gets XMARK if playX_en, OMARK if play0_en; move_cnt increments; ill=0.
- Latency:
  - Board and move_cnt reflect a move starting the cycle after the accepting edge, together with ill.
  - win and nospc are registered from the updated board and become valid one cycle later: accept at edge k, board at k+1, win/nospc at k+2.
- Win detection: 8 lines (rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6).
  - A line of three XMARK gives win=01; three OMARK gives win=10.
  - Both cannot occur, because moves freeze once win != 00.
- Sticky status: win holds until rst or clr. Once win != 00, every later request is flagged ill and the board is frozen.
- nospc = AND over all cells of (cell != EMPTY), registered. It can be 1 together with win != 00 (win on the 9th move); both flags report.
- move_cnt saturates at 9. A request while move_cnt == 9 is necessarily onto an occupied cell and is flagged ill.
- Turn order is enforced by the controller, not here. Two consecutive X moves are both accepted if the enables allow it.
- ill is a pulse, not a level. Back-to-back illegal requests produce back-to-back ill cycles.
- No combinational path from any input to any output. All outputs are registers or direct register slices.

Test Plan:
- Reset: drive rst=0 for 2 cycles, then release -> board=18'h0, win=00, nospc=0, ill=0, move_cnt=0.
- Legal then occupied: playX_en=1, move_pos=4, move_vld=1 -> board[9:8]=01, move_cnt=1, ill=0. Then play0_en=1, move_pos=4 -> ill=1 for one cycle, board unchanged, move_cnt=1.
- Range and enable conflicts: move_pos=9 or 15 with playX_en=1 -> ill pulse, no write. Both enables high with move_vld=1, move_pos=0 -> ill pulse, cell 0 stays EMPTY.
- X row win: alternate X0, O3, X1, O4, X2 -> win=01 exactly two cycles after the X2 edge. A following O5 request -> ill=1, cell 5 stays EMPTY.
- Draw: X0 O1 X2 O4 X3 O5 X7 O6 X8 -> nospc=1, win=00, move_cnt=9. A further request -> ill=1.
- clr/reset mid-game: after 3 moves assert clr=1 together with a legal move request -> board=0, move_cnt=0, ill=0, and the move is not written. Repeat the sequence with rst=0 instead -> same result.
